// File: rtl/mem_ctrl_pkg.sv
// Shared sizes and types for the two-client burst memory arbiter.
package mem_ctrl_pkg;
  localparam int BEATS  = 4;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int ADDR_W = 10;
  localparam int BLK_W  = 8;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side handshakes and main-memory port of the arbiter, bundled as one bus.
interface mem_arbiter_if;
  import mem_ctrl_pkg::*;

  logic                i_req;
  logic [BLK_W-1:0]    i_blk;
  logic [DATA_W-1:0]   i_rdata;
  logic                i_valid;
  logic                i_done;
  logic                d_req;
  logic                d_we;
  logic [BLK_W-1:0]    d_blk;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W-1:0]   d_rdata;
  logic                d_valid;
  logic                d_done;
  logic [BEAT_W-1:0]   beat;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  i_req, i_blk, d_req, d_we, d_blk, d_wdata, mem_rdata,
    output i_rdata, i_valid, i_done, d_rdata, d_valid, d_done,
           beat, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output i_req, i_blk, d_req, d_we, d_blk, d_wdata, mem_rdata,
    input  i_rdata, i_valid, i_done, d_rdata, d_valid, d_done,
           beat, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: bit 0 = I-cache, bit 1 = D-cache; last = 1 when D was served last.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache refills and D-cache refill/write-back bursts onto one main-memory port.
//   state | meaning
//   IDLE  | no owner; sample requests, grant round-robin
//   BURST | four beats to/from memory for the latched owner
//   DONE  | one-cycle done pulse to the owner
module mem_arbiter
  import mem_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [BLK_W-1:0]    blk_q, blk_d;
  owner_e              owner_q, owner_d;
  logic                we_q, we_d;
  owner_e              last_q, last_d;
  logic [1:0]          grant;

  rr_arbiter2 u_rr (
    .req   ({bus.d_req, bus.i_req}),
    .last  (last_q == OWN_D),
    .grant (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      blk_q   <= '0;
      owner_q <= OWN_I;
      we_q    <= 1'b0;
      last_q  <= OWN_I;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      blk_q   <= blk_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    blk_d   = blk_q;
    owner_d = owner_q;
    we_d    = we_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          state_d = BURST;
          beat_d  = '0;
          if (grant[1]) begin
            owner_d = OWN_D;
            blk_d   = bus.d_blk;
            we_d    = bus.d_we;
            last_d  = OWN_D;
          end else begin
            owner_d = OWN_I;
            blk_d   = bus.i_blk;
            we_d    = 1'b0;
            last_d  = OWN_I;
          end
        end
      end
      BURST: begin
        // natural 2-bit overflow brings beat back to 0 as the burst ends
        beat_d = beat_q + BEAT_W'(1);
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.i_rdata   = '0;
    bus.i_valid   = 1'b0;
    bus.i_done    = 1'b0;
    bus.d_rdata   = '0;
    bus.d_valid   = 1'b0;
    bus.d_done    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.beat      = beat_q;
    bus.mem_addr  = {blk_q, beat_q};
    case (state_q)
      BURST: begin
        if (owner_q == OWN_D) begin
          bus.d_valid = 1'b1;
          if (we_q) begin
            bus.mem_we    = 1'b1;
            bus.mem_wdata = bus.d_wdata;
          end else begin
            bus.d_rdata = bus.mem_rdata;
          end
        end else begin
          bus.i_valid = 1'b1;
          bus.i_rdata = bus.mem_rdata;
        end
      end
      DONE: begin
        if (owner_q == OWN_D) begin
          bus.d_done = 1'b1;
        end else begin
          bus.i_done = 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected beats/done pulses queued at request time, popped as the DUT responds.
module tb_mem_arbiter;
  import mem_ctrl_pkg::*;

  typedef struct {
    bit                is_done;
    bit                own_d;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [BEAT_W-1:0] bt;
    logic [DATA_W-1:0] wdata;
    int                cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t              sb_q[$];
  logic [DATA_W-1:0] mem    [1<<ADDR_W];
  logic [DATA_W-1:0] shadow [1<<ADDR_W];
  bit                mem_loaded    = 1'b0;
  bit                shadow_loaded = 1'b0;
  logic [DATA_W-1:0] d_wbase;
  int                cyc    = 0;
  int                n_chk  = 0;
  int                n_fail = 0;

  function automatic logic [DATA_W-1:0] init_word(int a);
    case (a)
      'h14:    return 32'hAAAA_0014;
      'h15:    return 32'hBBBB_0015;
      'h16:    return 32'hCCCC_0016;
      'h17:    return 32'hDDDD_0017;
      default: return 32'h5A00_0000 | DATA_W'(a);
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // main memory: combinational read, write on the clock edge
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int a = 0; a < (1<<ADDR_W); a++) mem[a] <= init_word(a);
      mem_loaded <= 1'b1;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  always_comb bus.mem_rdata = mem[bus.mem_addr];
  always_comb bus.d_wdata   = d_wbase + DATA_W'(bus.beat);

  always @(negedge clk) begin : monitor
    exp_t e;
    logic any;
    if (!shadow_loaded) begin
      for (int a = 0; a < (1<<ADDR_W); a++) shadow[a] = init_word(a);
      shadow_loaded = 1'b1;
    end
    if (!rst) begin
      any = bus.i_valid | bus.d_valid | bus.i_done | bus.d_done;
      if (!any) begin
        check("mem_we_outside_burst", 32'(bus.mem_we), 32'd0);
      end else if (sb_q.size() == 0) begin
        check("unexpected_output", 32'({bus.i_valid, bus.d_valid, bus.i_done, bus.d_done}), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("cycle", 32'(cyc), 32'(e.cyc));
        if (e.is_done) begin
          check("i_done", 32'(bus.i_done), 32'(!e.own_d));
          check("d_done", 32'(bus.d_done), 32'(e.own_d));
          check("valid_in_done", 32'({bus.i_valid, bus.d_valid, bus.mem_we}), 32'd0);
        end else begin
          check("i_valid", 32'(bus.i_valid), 32'(!e.own_d));
          check("d_valid", 32'(bus.d_valid), 32'(e.own_d));
          check("beat", 32'(bus.beat), 32'(e.bt));
          check("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
          check("mem_we", 32'(bus.mem_we), 32'(e.we));
          check("done_in_burst", 32'({bus.i_done, bus.d_done}), 32'd0);
          if (e.we) begin
            check("mem_wdata", bus.mem_wdata, e.wdata);
            check("rdata_during_write", bus.i_rdata | bus.d_rdata, 32'd0);
            shadow[e.addr] = e.wdata;
          end else if (e.own_d) begin
            check("d_rdata", bus.d_rdata, shadow[e.addr]);
            check("i_rdata_not_owner", bus.i_rdata, 32'd0);
          end else begin
            check("i_rdata", bus.i_rdata, shadow[e.addr]);
            check("d_rdata_not_owner", bus.d_rdata, 32'd0);
          end
        end
      end
    end
  end

  task automatic push_xfer(bit own_d, bit we, logic [BLK_W-1:0] blk,
                           logic [DATA_W-1:0] wbase, int start);
    exp_t e;
    for (int b = 0; b < BEATS; b++) begin
      e.is_done = 1'b0;
      e.own_d   = own_d;
      e.we      = we;
      e.addr    = {blk, BEAT_W'(b)};
      e.bt      = BEAT_W'(b);
      e.wdata   = wbase + DATA_W'(b);
      e.cyc     = start + b;
      sb_q.push_back(e);
    end
    e.is_done = 1'b1;
    e.we      = 1'b0;
    e.cyc     = start + BEATS;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(bit own_d, bit keep);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = own_d ? bus.d_done : bus.i_done;
    end
    check(own_d ? "d_done_seen" : "i_done_seen", 32'(seen), 32'd1);
    if (!keep) begin
      if (own_d) bus.d_req = 1'b0;
      else       bus.i_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    bus.i_req  = 1'b0;
    bus.i_blk  = '0;
    bus.d_req  = 1'b0;
    bus.d_we   = 1'b0;
    bus.d_blk  = '0;
    d_wbase    = '0;
    rst        = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_i_valid", 32'(bus.i_valid), 32'd0);
    check("rst_d_valid", 32'(bus.d_valid), 32'd0);
    check("rst_i_done",  32'(bus.i_done),  32'd0);
    check("rst_d_done",  32'(bus.d_done),  32'd0);
    check("rst_mem_we",  32'(bus.mem_we),  32'd0);
    check("rst_beat",    32'(bus.beat),    32'd0);
    rst = 1'b0;
    @(negedge clk);

    // I-cache refill of block 0x05 (words 0x14..0x17)
    bus.i_blk = 8'h05;
    bus.i_req = 1'b1;
    push_xfer(1'b0, 1'b0, 8'h05, '0, cyc + 1);
    wait_done(1'b0, 1'b0);
    @(negedge clk);

    // D-cache write-back of block 0xFF, then read it back
    bus.d_blk = 8'hFF;
    bus.d_we  = 1'b1;
    d_wbase   = 32'h100;
    bus.d_req = 1'b1;
    push_xfer(1'b1, 1'b1, 8'hFF, 32'h100, cyc + 1);
    wait_done(1'b1, 1'b0);
    @(negedge clk);
    bus.d_we  = 1'b0;
    bus.d_req = 1'b1;
    push_xfer(1'b1, 1'b0, 8'hFF, '0, cyc + 1);
    wait_done(1'b1, 1'b0);
    @(negedge clk);

    // two ties after reset: D wins both, I follows each time
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int t = 0; t < 2; t++) begin
      bus.d_blk = 8'h20 + 8'(2 * t);
      bus.i_blk = 8'h21 + 8'(2 * t);
      bus.d_we  = 1'b0;
      bus.d_req = 1'b1;
      bus.i_req = 1'b1;
      push_xfer(1'b1, 1'b0, bus.d_blk, '0, cyc + 1);
      push_xfer(1'b0, 1'b0, bus.i_blk, '0, cyc + 7);
      wait_done(1'b1, 1'b0);
      wait_done(1'b0, 1'b0);
      @(negedge clk);
    end

    // reset while beat 2 of a write-back is on the bus
    bus.d_blk = 8'h30;
    bus.d_we  = 1'b1;
    d_wbase   = 32'h200;
    bus.d_req = 1'b1;
    push_xfer(1'b1, 1'b1, 8'h30, 32'h200, cyc + 1);
    hit = 1'b0;
    for (int k = 0; k < 10 && !hit; k++) begin
      @(negedge clk);
      hit = bus.d_valid && (bus.beat == BEAT_W'(1));
    end
    check("reached_beat1", 32'(hit), 32'd1);
    @(posedge clk);
    #1;
    check("pre_abort_beat", 32'(bus.beat), 32'd2);
    rst       = 1'b1;
    bus.d_req = 1'b0;
    #1;
    check("abort_mem_we", 32'(bus.mem_we),  32'd0);
    check("abort_beat",   32'(bus.beat),    32'd0);
    check("abort_d_valid",32'(bus.d_valid), 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("d_done_after_abort", 32'(bus.d_done), 32'd0);
    end
    bus.d_blk = 8'h31;
    bus.d_we  = 1'b0;
    bus.d_req = 1'b1;
    push_xfer(1'b1, 1'b0, 8'h31, '0, cyc + 1);
    wait_done(1'b1, 1'b0);
    @(negedge clk);

    // request held through d_done: back-to-back second transfer, I side silent
    bus.d_blk = 8'h40;
    bus.d_we  = 1'b0;
    bus.d_req = 1'b1;
    push_xfer(1'b1, 1'b0, 8'h40, '0, cyc + 1);
    push_xfer(1'b1, 1'b0, 8'h40, '0, cyc + 7);
    wait_done(1'b1, 1'b1);
    wait_done(1'b1, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
